// File: rtl/coproc_cmd_sequencer_pkg.sv
// coproc_pkg: shared types and constants for the coprocessor command sequencer.
//   seq_state_e       sequencer FSM state encoding
//   STATUS_*          first byte of every response frame
//   *_DEF             default parameter values for the top block
package coproc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_SEND_ST  = 3'd3,
        ST_SEND_HI  = 3'd4,
        ST_SEND_LO  = 3'd5
    } seq_state_e;

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_BAD_OP  = 8'h01;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

    localparam int NUM_OPCODES_DEF    = 8;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // True in the three states that present a response byte to TX.
    function automatic logic is_send_state(seq_state_e s);
        return (s == ST_SEND_ST) || (s == ST_SEND_HI) || (s == ST_SEND_LO);
    endfunction

endpackage

// File: rtl/coproc_cmd_sequencer_if.sv
// coproc_cmd_sequencer_if: command, ALU and TX byte signals of the sequencer.
//   master modport : the sequencer (drives ALU start/operands, TX byte, status)
//   slave modport  : the surrounding demux / ALU / UART TX side
// Signal names keep the block-level i_/o_ naming as seen from the sequencer.
interface coproc_cmd_sequencer_if;

    // command from the RX byte demux
    logic        i_cmd_valid;
    logic [7:0]  i_num_1;
    logic [7:0]  i_num_2;
    logic [7:0]  i_opcode;
    // ALU
    logic        o_alu_start;
    logic [7:0]  o_alu_a;
    logic [7:0]  o_alu_b;
    logic [7:0]  o_alu_op;
    logic        i_alu_done;
    logic [15:0] i_alu_result;
    // UART TX byte stream
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    // status
    logic        o_busy;
    logic        o_overrun;

    modport master (
        input  i_cmd_valid, i_num_1, i_num_2, i_opcode,
        input  i_alu_done, i_alu_result, i_tx_ready,
        output o_alu_start, o_alu_a, o_alu_b, o_alu_op,
        output o_tx_valid, o_tx_data, o_busy, o_overrun
    );

    modport slave (
        output i_cmd_valid, i_num_1, i_num_2, i_opcode,
        output i_alu_done, i_alu_result, i_tx_ready,
        input  o_alu_start, o_alu_a, o_alu_b, o_alu_op,
        input  o_tx_valid, o_tx_data, o_busy, o_overrun
    );

endinterface

// File: rtl/coproc_tx_serializer.sv
// coproc_tx_serializer: presents the 3-byte response frame on a valid/ready
// byte port. The byte sequencing itself is the sequencer's SEND_* states;
// this block selects the byte for the current state and reports the handshake.
//   state    in   current sequencer state
//   status   in   frame byte 0
//   result   in   frame bytes 1 (hi) and 2 (lo)
//   tx_ready in   TX accepts the byte this cycle
//   tx_valid out  a frame byte is being offered
//   tx_data  out  the offered byte; stable while the state holds
//   fire     out  handshake this cycle (tx_valid && tx_ready)
module coproc_tx_serializer
    import coproc_pkg::*;
(
    input  seq_state_e  state,
    input  logic [7:0]  status,
    input  logic [15:0] result,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        fire
);

    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_SEND_ST: tx_data = status;
            ST_SEND_HI: tx_data = result[15:8];
            ST_SEND_LO: tx_data = result[7:0];
            default:    tx_data = 8'h00;
        endcase
    end

    // Valid is a pure function of the registered state, so it never glitches
    // and drops in the cycle after the state leaves SEND_LO or is reset.
    assign tx_valid = is_send_state(state);
    assign fire     = tx_valid && tx_ready;

endmodule

// File: rtl/coproc_cmd_sequencer.sv
// coproc_cmd_sequencer: runs one coprocessor transaction per command.
// Latches a command in IDLE, rejects illegal opcodes, pulses the ALU start,
// waits for the result with a timeout and streams status/result_hi/result_lo.
//   i_clk          in   system clock
//   reset          in   synchronous active-high reset
//   bus (master)   command inputs, ALU start/operands/result, TX byte port,
//                  o_busy (not IDLE) and o_overrun (sticky dropped-command flag)
// Parameters:
//   NUM_OPCODES    opcodes 0..NUM_OPCODES-1 are dispatched, others rejected
//   TIMEOUT_CYCLES cycles allowed from ALU start to done (1..65535)
module coproc_cmd_sequencer
    import coproc_pkg::*;
#(
    parameter int NUM_OPCODES    = NUM_OPCODES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   i_clk,
    input  logic                   reset,
    coproc_cmd_sequencer_if.master bus
);

    // 9 bits so NUM_OPCODES = 256 (every opcode legal) still compares correctly.
    localparam logic [8:0]  NUM_OPS_W = 9'(NUM_OPCODES);
    localparam logic [15:0] TMO_W     = 16'(TIMEOUT_CYCLES);

    seq_state_e  state, state_nxt;

    logic [7:0]  a_q, b_q, op_q;
    logic [7:0]  status_q;
    logic [15:0] result_q;
    logic [15:0] tmo_cnt;
    logic        overrun_q;

    logic [15:0] cnt_inc;
    logic        timed_out;
    logic        tx_fire;

    // FSM-side control strobes
    logic        cmd_take;
    logic        ld_ok;
    logic        ld_bad;
    logic        ld_tmo;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cnt_inc   = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
    // The first WAIT_ALU cycle sees count 0, so the limit is hit on the
    // TIMEOUT_CYCLES-th wait cycle and SEND_ST follows one cycle later.
    assign timed_out = (cnt_inc >= TMO_W);

    always_comb begin
        state_nxt = state;
        cmd_take  = 1'b0;
        ld_ok     = 1'b0;
        ld_bad    = 1'b0;
        ld_tmo    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_cmd_valid) begin
                    cmd_take = 1'b1;
                    if ({1'b0, bus.i_opcode} < NUM_OPS_W) begin
                        state_nxt = ST_DISPATCH;
                    end else begin
                        ld_bad    = 1'b1;
                        state_nxt = ST_SEND_ST;
                    end
                end
            end
            ST_DISPATCH: state_nxt = ST_WAIT_ALU;
            ST_WAIT_ALU: begin
                // done takes priority over a timeout in the same cycle
                if (bus.i_alu_done) begin
                    ld_ok     = 1'b1;
                    state_nxt = ST_SEND_ST;
                end else if (timed_out) begin
                    ld_tmo    = 1'b1;
                    state_nxt = ST_SEND_ST;
                end
            end
            ST_SEND_ST: if (tx_fire) state_nxt = ST_SEND_HI;
            ST_SEND_HI: if (tx_fire) state_nxt = ST_SEND_LO;
            ST_SEND_LO: if (tx_fire) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            op_q      <= 8'h00;
            status_q  <= 8'h00;
            result_q  <= 16'h0000;
            tmo_cnt   <= 16'h0000;
            overrun_q <= 1'b0;
        end else begin
            state <= state_nxt;

            if (cmd_take) begin
                a_q  <= bus.i_num_1;
                b_q  <= bus.i_num_2;
                op_q <= bus.i_opcode;
            end

            // Anything outside IDLE is busy, including the last SEND_LO cycle.
            if (bus.i_cmd_valid && (state != ST_IDLE))
                overrun_q <= 1'b1;

            if (state == ST_DISPATCH)
                tmo_cnt <= 16'h0000;
            else if (state == ST_WAIT_ALU)
                tmo_cnt <= cnt_inc;

            if (ld_ok) begin
                status_q <= STATUS_OK;
                result_q <= bus.i_alu_result;
            end else if (ld_bad) begin
                status_q <= STATUS_BAD_OP;
                result_q <= 16'h0000;
            end else if (ld_tmo) begin
                status_q <= STATUS_TIMEOUT;
                result_q <= 16'h0000;
            end
        end
    end

    coproc_tx_serializer u_tx (
        .state    (state),
        .status   (status_q),
        .result   (result_q),
        .tx_ready (bus.i_tx_ready),
        .tx_valid (bus.o_tx_valid),
        .tx_data  (bus.o_tx_data),
        .fire     (tx_fire)
    );

    assign bus.o_alu_start = (state == ST_DISPATCH);
    assign bus.o_alu_a     = a_q;
    assign bus.o_alu_b     = b_q;
    assign bus.o_alu_op    = op_q;
    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_coproc_cmd_sequencer.sv
module tb_coproc_cmd_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   hs_cnt = 0;
    int   hs0;
    logic [7:0] bp_bytes [3];

    always #5 clk = ~clk;

    coproc_cmd_sequencer_if bus();

    coproc_cmd_sequencer #(.NUM_OPCODES(8), .TIMEOUT_CYCLES(10)) dut (
        .i_clk (clk),
        .reset (reset),
        .bus   (bus)
    );

    // TX handshakes as seen at the clock edge
    always @(posedge clk)
        if (!reset && bus.o_tx_valid && bus.i_tx_ready) hs_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse i_cmd_valid for one cycle, then scramble the fields so that any
    // late capture shows up. Returns in the cycle after the command edge.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        bus.i_cmd_valid = 1'b1;
        bus.i_num_1     = a;
        bus.i_num_2     = b;
        bus.i_opcode    = op;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_num_1     = ~a;
        bus.i_num_2     = ~b;
        bus.i_opcode    = 8'hC3;
    endtask

    // Frame check with i_tx_ready held high: one byte per cycle, then idle.
    task automatic chk_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        chk({tag, " st valid"}, 32'(bus.o_tx_valid), 32'd1);
        chk({tag, " st data"},  32'(bus.o_tx_data),  32'(b0));
        tick();
        chk({tag, " hi valid"}, 32'(bus.o_tx_valid), 32'd1);
        chk({tag, " hi data"},  32'(bus.o_tx_data),  32'(b1));
        tick();
        chk({tag, " lo valid"}, 32'(bus.o_tx_valid), 32'd1);
        chk({tag, " lo data"},  32'(bus.o_tx_data),  32'(b2));
        tick();
        chk({tag, " end valid"}, 32'(bus.o_tx_valid), 32'd0);
        chk({tag, " end busy"},  32'(bus.o_busy),     32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.i_cmd_valid  = 1'b0;
        bus.i_num_1      = 8'h00;
        bus.i_num_2      = 8'h00;
        bus.i_opcode     = 8'h00;
        bus.i_alu_done   = 1'b0;
        bus.i_alu_result = 16'h0000;
        bus.i_tx_ready   = 1'b1;
        bp_bytes[0] = 8'h00;
        bp_bytes[1] = 8'hBE;
        bp_bytes[2] = 8'hEF;

        // ---- reset state
        tick();
        tick();
        chk("rst busy",    32'(bus.o_busy),      32'd0);
        chk("rst start",   32'(bus.o_alu_start), 32'd0);
        chk("rst txvalid", 32'(bus.o_tx_valid),  32'd0);
        chk("rst overrun", 32'(bus.o_overrun),   32'd0);
        chk("rst alu_a",   32'(bus.o_alu_a),     32'd0);
        reset = 1'b0;
        tick();

        // ---- stray ALU done in IDLE is ignored
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'hAAAA;
        tick();
        bus.i_alu_done   = 1'b0;
        chk("stray done busy", 32'(bus.o_busy), 32'd0);

        // ---- legal op: start at N+1, result 3 cycles after start
        send_cmd(8'h12, 8'h34, 8'h02);
        chk("legal start", 32'(bus.o_alu_start), 32'd1);
        chk("legal a",     32'(bus.o_alu_a),     32'h12);
        chk("legal b",     32'(bus.o_alu_b),     32'h34);
        chk("legal op",    32'(bus.o_alu_op),    32'h02);
        chk("legal busy",  32'(bus.o_busy),      32'd1);
        tick();
        chk("legal start 1cyc", 32'(bus.o_alu_start), 32'd0);
        tick();
        tick();
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'h0046;
        tick();
        bus.i_alu_done   = 1'b0;
        bus.i_alu_result = 16'hDEAD;
        chk_frame("legal", 8'h00, 8'h00, 8'h46);
        chk("legal a held", 32'(bus.o_alu_a), 32'h12);

        // ---- bad opcode 0x09, then boundary opcode 0x08
        send_cmd(8'h55, 8'h66, 8'h09);
        chk("bad start", 32'(bus.o_alu_start), 32'd0);
        chk("bad op",    32'(bus.o_alu_op),    32'h09);
        chk_frame("bad09", 8'h01, 8'h00, 8'h00);
        send_cmd(8'h01, 8'h01, 8'h08);
        chk("bad08 start", 32'(bus.o_alu_start), 32'd0);
        chk_frame("bad08", 8'h01, 8'h00, 8'h00);

        // ---- timeout (10 cycles): response 11 cycles after start
        send_cmd(8'h01, 8'h02, 8'h03);
        chk("tmo start", 32'(bus.o_alu_start), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("tmo no restart", 32'(bus.o_alu_start), 32'd0);
            chk("tmo no tx",      32'(bus.o_tx_valid),  32'd0);
        end
        tick();
        chk_frame("tmo", 8'h02, 8'h00, 8'h00);

        // ---- done and timeout in the same cycle: done wins
        send_cmd(8'h21, 8'h43, 8'h05);
        repeat (10) tick();
        chk("tie no tx yet", 32'(bus.o_tx_valid), 32'd0);
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'h1234;
        tick();
        bus.i_alu_done   = 1'b0;
        chk_frame("tie", 8'h00, 8'h12, 8'h34);

        // ---- TX backpressure on result 0xBEEF
        bus.i_tx_ready = 1'b0;
        send_cmd(8'h0A, 8'h0B, 8'h01);
        tick();
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'hBEEF;
        tick();
        bus.i_alu_done   = 1'b0;
        bus.i_alu_result = 16'h0000;
        hs0 = hs_cnt;
        for (int i = 0; i < 3; i++) begin
            repeat (5) begin
                chk("bp valid", 32'(bus.o_tx_valid), 32'd1);
                chk("bp hold",  32'(bus.o_tx_data),  32'(bp_bytes[i]));
                tick();
            end
            bus.i_tx_ready = 1'b1;
            chk("bp data", 32'(bus.o_tx_data), 32'(bp_bytes[i]));
            tick();
            bus.i_tx_ready = 1'b0;
        end
        chk("bp end valid", 32'(bus.o_tx_valid), 32'd0);
        tick();
        chk("bp handshakes", 32'(hs_cnt - hs0), 32'd3);
        bus.i_tx_ready = 1'b1;

        // ---- overrun: second command during WAIT_ALU
        chk("ovr before", 32'(bus.o_overrun), 32'd0);
        send_cmd(8'h11, 8'h22, 8'h00);
        tick();
        send_cmd(8'hAA, 8'hBB, 8'h05);
        chk("ovr set",     32'(bus.o_overrun), 32'd1);
        chk("ovr a kept",  32'(bus.o_alu_a),   32'h11);
        chk("ovr op kept", 32'(bus.o_alu_op),  32'h00);
        chk("ovr no start", 32'(bus.o_alu_start), 32'd0);
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'h0102;
        tick();
        bus.i_alu_done   = 1'b0;
        chk_frame("ovr", 8'h00, 8'h01, 8'h02);
        chk("ovr sticky", 32'(bus.o_overrun), 32'd1);

        // later command in IDLE works; command on the return-to-IDLE cycle is dropped
        send_cmd(8'h03, 8'h04, 8'h02);
        chk("after start", 32'(bus.o_alu_start), 32'd1);
        chk("after a",     32'(bus.o_alu_a),     32'h03);
        tick();
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'h0007;
        tick();
        bus.i_alu_done   = 1'b0;
        chk("after st", 32'(bus.o_tx_data), 32'h00);
        tick();
        chk("after hi", 32'(bus.o_tx_data), 32'h00);
        tick();
        chk("after lo", 32'(bus.o_tx_data), 32'h07);
        send_cmd(8'h01, 8'h01, 8'h01);
        chk("lastcyc busy",  32'(bus.o_busy),     32'd0);
        chk("lastcyc valid", 32'(bus.o_tx_valid), 32'd0);
        chk("lastcyc a",     32'(bus.o_alu_a),    32'h03);
        tick();
        chk("lastcyc no start", 32'(bus.o_alu_start), 32'd0);
        chk("lastcyc ovr",      32'(bus.o_overrun),   32'd1);

        // ---- reset during SEND_HI
        send_cmd(8'h0F, 8'h0E, 8'h0F);
        chk("rmf st", 32'(bus.o_tx_data), 32'h01);
        tick();
        chk("rmf hi valid", 32'(bus.o_tx_valid), 32'd1);
        chk("rmf hi data",  32'(bus.o_tx_data),  32'h00);
        reset = 1'b1;
        bus.i_tx_ready = 1'b0;
        tick();
        reset = 1'b0;
        bus.i_tx_ready = 1'b1;
        chk("rmf valid",   32'(bus.o_tx_valid), 32'd0);
        chk("rmf busy",    32'(bus.o_busy),     32'd0);
        chk("rmf overrun", 32'(bus.o_overrun),  32'd0);
        chk("rmf a",       32'(bus.o_alu_a),    32'd0);
        send_cmd(8'h05, 8'h06, 8'h04);
        chk("post start", 32'(bus.o_alu_start), 32'd1);
        chk("post a",     32'(bus.o_alu_a),     32'h05);
        chk("post b",     32'(bus.o_alu_b),     32'h06);
        chk("post op",    32'(bus.o_alu_op),    32'h04);
        tick();
        bus.i_alu_done   = 1'b1;
        bus.i_alu_result = 16'h001E;
        tick();
        bus.i_alu_done   = 1'b0;
        chk_frame("post", 8'h00, 8'h00, 8'h1E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
